// File: rtl/inst_set_pkg.sv
// ============================================================================
// inst_set_pkg : opcode map, instruction field positions and opcode classifiers
// Rev 1.0
// ============================================================================
`default_nettype none

package inst_set_pkg;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int SUB_HI = 29;
    localparam int SUB_LO = 26;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 21;
    localparam int RS_HI  = 20;
    localparam int RS_LO  = 16;
    localparam int RT_HI  = 15;
    localparam int RT_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;
    localparam int FBIT   = 30;

    // Bit 30 selects the float file; a zero sub-field [29:26] marks rd as a source.
    typedef enum logic [5:0] {
        OP_SW   = 6'h00,
        OP_ADD  = 6'h01,
        OP_SUB  = 6'h02,
        OP_BEQ  = 6'h04,
        OP_BNE  = 6'h05,
        OP_BLT  = 6'h06,
        OP_LW   = 6'h08,
        OP_FLW  = 6'h10,
        OP_FADD = 6'h11,
        OP_FMUL = 6'h13
    } opcode_e;

    function automatic logic is_branch_op(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT);
    endfunction

    function automatic logic is_load_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_FLW);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bypass_mux.sv
// ============================================================================
// bypass_mux : picks the youngest matching bypass write, else the default data
// Rev 1.0
// ============================================================================
`default_nettype none

module bypass_mux #(
    parameter int NUM_BYPASS = 2,
    parameter int XLEN       = 32,
    parameter int RBITS      = 5
) (
    input  logic [RBITS-1:0]           i_addr,
    input  logic                       i_fmode,
    input  logic [XLEN-1:0]            i_dflt,
    input  logic [NUM_BYPASS-1:0]      i_byp_valid,
    input  logic [NUM_BYPASS-1:0]      i_byp_fmode,
    input  logic [NUM_BYPASS*RBITS-1:0] i_byp_rd,
    input  logic [NUM_BYPASS*XLEN-1:0] i_byp_data,
    output logic [XLEN-1:0]            o_data
);

    // Scan oldest to youngest so that the lowest index overrides last.
    always_comb begin
        o_data = i_dflt;
        if (!((i_addr == '0) && !i_fmode)) begin
            for (int i = NUM_BYPASS - 1; i >= 0; i--) begin
                if (i_byp_valid[i] && (i_byp_fmode[i] == i_fmode) &&
                    (i_byp_rd[i*RBITS +: RBITS] == i_addr)) begin
                    o_data = i_byp_data[i*XLEN +: XLEN];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// decode_stage : handshaked decode register with operand bypass, load-use
//                bubble insertion, flush and a saturating bubble counter
// Rev 1.0
// ============================================================================
`default_nettype none

module decode_stage
    import inst_set_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RBITS      = 5,
    parameter int NUM_BYPASS = 2,
    parameter int CNT_W      = 32
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [XLEN-1:0]             in_pc,
    input  logic [31:0]                 in_inst,
    input  logic                        flush,
    output logic [RBITS-1:0]            rf_addr1,
    output logic [RBITS-1:0]            rf_addr2,
    output logic                        rf_fmode1,
    output logic                        rf_fmode2,
    input  logic [XLEN-1:0]             rf_data1,
    input  logic [XLEN-1:0]             rf_data2,
    input  logic [NUM_BYPASS-1:0]       byp_valid,
    input  logic [NUM_BYPASS-1:0]       byp_fmode,
    input  logic [NUM_BYPASS*RBITS-1:0] byp_rd,
    input  logic [NUM_BYPASS*XLEN-1:0]  byp_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [5:0]                  opecode,
    output logic [15:0]                 offset,
    output logic [XLEN-1:0]             pc_out,
    output logic [XLEN-1:0]             rs,
    output logic [XLEN-1:0]             rt,
    output logic [RBITS-1:0]            rd_no,
    output logic [RBITS-1:0]            rs_no,
    output logic [RBITS-1:0]            rt_no,
    output logic                        fmode1_reg,
    output logic                        fmode2_reg,
    output logic [CNT_W-1:0]            bubble_cnt
);

    logic [5:0]       w_op;
    logic [3:0]       w_sub;
    logic [RBITS-1:0] w_rd_field;
    logic             w_advance;
    logic             w_match;
    logic             w_hazard;
    logic             w_load;
    logic [XLEN-1:0]  w_rs_sel;
    logic [XLEN-1:0]  w_rt_sel;
    logic [XLEN-1:0]  w_rs_hold;
    logic [XLEN-1:0]  w_rt_hold;

    logic             r_out_valid;
    logic [5:0]       r_opecode;
    logic [15:0]      r_offset;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_rs;
    logic [XLEN-1:0]  r_rt;
    logic [RBITS-1:0] r_rd_no;
    logic [RBITS-1:0] r_rs_no;
    logic [RBITS-1:0] r_rt_no;
    logic             r_fmode1;
    logic             r_fmode2;
    logic [CNT_W-1:0] r_bubble_cnt;

    assign w_op       = in_inst[OP_HI:OP_LO];
    assign w_sub      = in_inst[SUB_HI:SUB_LO];
    assign w_rd_field = RBITS'(in_inst[RD_HI:RD_LO]);

    assign rf_addr1  = RBITS'(in_inst[RS_HI:RS_LO]);
    assign rf_addr2  = ((w_sub == 4'd0) || is_branch_op(w_op)) ? w_rd_field
                                                                : RBITS'(in_inst[RT_HI:RT_LO]);
    assign rf_fmode1 = in_inst[FBIT] && (w_sub != 4'd0);
    assign rf_fmode2 = in_inst[FBIT];

    // A held load's destination file is carried in fmode2; integer r0 never stalls.
    assign w_advance = !r_out_valid || out_ready;
    assign w_match   = ((r_rd_no == rf_addr1) && (r_fmode2 == rf_fmode1)) ||
                       ((r_rd_no == rf_addr2) && (r_fmode2 == rf_fmode2));
    assign w_hazard  = in_valid && r_out_valid && is_load_op(r_opecode) && w_match &&
                       !((r_rd_no == '0) && !r_fmode2);
    assign in_ready  = w_advance && !w_hazard && !flush;
    assign w_load    = in_valid && in_ready;

    bypass_mux #(.NUM_BYPASS(NUM_BYPASS), .XLEN(XLEN), .RBITS(RBITS)) u_sel_rs (
        .i_addr(rf_addr1), .i_fmode(rf_fmode1), .i_dflt(rf_data1),
        .i_byp_valid(byp_valid), .i_byp_fmode(byp_fmode), .i_byp_rd(byp_rd),
        .i_byp_data(byp_data), .o_data(w_rs_sel)
    );

    bypass_mux #(.NUM_BYPASS(NUM_BYPASS), .XLEN(XLEN), .RBITS(RBITS)) u_sel_rt (
        .i_addr(rf_addr2), .i_fmode(rf_fmode2), .i_dflt(rf_data2),
        .i_byp_valid(byp_valid), .i_byp_fmode(byp_fmode), .i_byp_rd(byp_rd),
        .i_byp_data(byp_data), .o_data(w_rt_sel)
    );

    bypass_mux #(.NUM_BYPASS(NUM_BYPASS), .XLEN(XLEN), .RBITS(RBITS)) u_hold_rs (
        .i_addr(r_rs_no), .i_fmode(r_fmode1), .i_dflt(r_rs),
        .i_byp_valid(byp_valid), .i_byp_fmode(byp_fmode), .i_byp_rd(byp_rd),
        .i_byp_data(byp_data), .o_data(w_rs_hold)
    );

    bypass_mux #(.NUM_BYPASS(NUM_BYPASS), .XLEN(XLEN), .RBITS(RBITS)) u_hold_rt (
        .i_addr(r_rt_no), .i_fmode(r_fmode2), .i_dflt(r_rt),
        .i_byp_valid(byp_valid), .i_byp_fmode(byp_fmode), .i_byp_rd(byp_rd),
        .i_byp_data(byp_data), .o_data(w_rt_hold)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_out_valid  <= 1'b0;
            r_opecode    <= '0;
            r_offset     <= '0;
            r_pc         <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd_no      <= '0;
            r_rs_no      <= '0;
            r_rt_no      <= '0;
            r_fmode1     <= 1'b0;
            r_fmode2     <= 1'b0;
            r_bubble_cnt <= '0;
        end else begin
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_load) begin
                r_out_valid <= 1'b1;
                r_opecode   <= w_op;
                r_offset    <= in_inst[IMM_HI:IMM_LO];
                r_pc        <= in_pc;
                r_rd_no     <= w_rd_field;
                r_rs_no     <= rf_addr1;
                r_rt_no     <= rf_addr2;
                r_fmode1    <= rf_fmode1;
                r_fmode2    <= rf_fmode2;
            end else if (w_advance) begin
                r_out_valid <= 1'b0;
                if (w_hazard && (r_bubble_cnt != {CNT_W{1'b1}})) begin
                    r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            // Operands track in-flight writebacks while held; idle beats stay quiet.
            if (w_load && !flush) begin
                r_rs <= w_rs_sel;
                r_rt <= w_rt_sel;
            end else if (r_out_valid) begin
                r_rs <= w_rs_hold;
                r_rt <= w_rt_hold;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign opecode    = r_opecode;
    assign offset     = r_offset;
    assign pc_out     = r_pc;
    assign rs         = r_rs;
    assign rt         = r_rt;
    assign rd_no      = r_rd_no;
    assign rs_no      = r_rs_no;
    assign rt_no      = r_rt_no;
    assign fmode1_reg = r_fmode1;
    assign fmode2_reg = r_fmode2;
    assign bubble_cnt = r_bubble_cnt;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// tb_decode_stage : directed and random stimulus against a cycle-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_decode_stage;

    localparam int CNT_W = 4;
    localparam int MAXB  = 15;

    localparam logic [5:0] OPC_SW = 6'h00, OPC_ADD = 6'h01, OPC_SUB = 6'h02,
                           OPC_BEQ = 6'h04, OPC_BNE = 6'h05, OPC_BLT = 6'h06,
                           OPC_LW = 6'h08, OPC_FLW = 6'h10, OPC_FADD = 6'h11,
                           OPC_FMUL = 6'h13;

    logic        clk = 1'b0;
    logic        rstn, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_pc, in_inst, rf_data1, rf_data2, pc_out, rs, rt;
    logic [4:0]  rf_addr1, rf_addr2, rd_no, rs_no, rt_no;
    logic        rf_fmode1, rf_fmode2, fmode1_reg, fmode2_reg;
    logic [1:0]  byp_valid, byp_fmode;
    logic [9:0]  byp_rd;
    logic [63:0] byp_data;
    logic [5:0]  opecode;
    logic [15:0] offset;
    logic [CNT_W-1:0] bubble_cnt;

    logic [31:0] rf_int [32];
    logic [31:0] rf_flt [32];
    logic [5:0]  ops [10] = '{OPC_SW, OPC_ADD, OPC_SUB, OPC_BEQ, OPC_BNE, OPC_BLT,
                              OPC_LW, OPC_FLW, OPC_FADD, OPC_FMUL};

    int checks = 0;
    int errors = 0;

    // Model of the stage contents
    logic        m_valid, m_f1, m_f2;
    logic [5:0]  m_op;
    logic [15:0] m_off;
    logic [31:0] m_pc, m_rs, m_rt;
    logic [4:0]  m_rd, m_rsn, m_rtn;
    int          m_bub;

    always #5 clk = ~clk;

    assign rf_data1 = rf_fmode1 ? rf_flt[rf_addr1] : rf_int[rf_addr1];
    assign rf_data2 = rf_fmode2 ? rf_flt[rf_addr2] : rf_int[rf_addr2];

    decode_stage #(.XLEN(32), .RBITS(5), .NUM_BYPASS(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .flush(flush),
        .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_fmode1(rf_fmode1), .rf_fmode2(rf_fmode2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .byp_valid(byp_valid), .byp_fmode(byp_fmode), .byp_rd(byp_rd), .byp_data(byp_data),
        .out_valid(out_valid), .out_ready(out_ready), .opecode(opecode), .offset(offset),
        .pc_out(pc_out), .rs(rs), .rt(rt), .rd_no(rd_no), .rs_no(rs_no), .rt_no(rt_no),
        .fmode1_reg(fmode1_reg), .fmode2_reg(fmode2_reg), .bubble_cnt(bubble_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rsf, input logic [4:0] rtf,
                                        input logic [10:0] lo);
        return {op, rd, rsf, rtf, lo};
    endfunction

    function automatic void decode(input logic [31:0] w, output logic [4:0] a1,
                                   output logic [4:0] a2, output logic f1, output logic f2);
        logic [5:0] op;
        op = w[31:26];
        a1 = w[20:16];
        a2 = ((w[29:26] == 4'd0) || (op inside {OPC_BEQ, OPC_BNE, OPC_BLT})) ? w[25:21] : w[15:11];
        f1 = w[30] && (w[29:26] != 4'd0);
        f2 = w[30];
    endfunction

    // Youngest matching writeback wins; integer r0 is hard-wired.
    function automatic logic [31:0] fwd(input logic [4:0] a, input logic f, input logic [31:0] dflt);
        if (a == 5'd0 && !f) return dflt;
        for (int i = 0; i < 2; i++)
            if (byp_valid[i] && byp_fmode[i] == f && byp_rd[i*5 +: 5] == a)
                return byp_data[i*32 +: 32];
        return dflt;
    endfunction

    task automatic cycle();
        logic [4:0] a1, a2;
        logic f1, f2, adv, haz, rdy, was_rst;
        #1;
        decode(in_inst, a1, a2, f1, f2);
        chk("rf_addr1", rf_addr1, a1);
        chk("rf_addr2", rf_addr2, a2);
        chk("rf_fmode1", rf_fmode1, f1);
        chk("rf_fmode2", rf_fmode2, f2);
        adv = !m_valid || out_ready;
        haz = in_valid && m_valid && (m_op == OPC_LW || m_op == OPC_FLW) &&
              !(m_rd == 5'd0 && !m_f2) &&
              ((m_rd == a1 && m_f2 == f1) || (m_rd == a2 && m_f2 == f2));
        rdy = adv && !haz && !flush;
        if (rstn) chk("in_ready", in_ready, rdy);
        was_rst = !rstn;
        if (!rstn) begin
            m_valid = 0; m_bub = 0; m_op = 0; m_off = 0; m_pc = 0; m_rs = 0; m_rt = 0;
            m_rd = 0; m_rsn = 0; m_rtn = 0; m_f1 = 0; m_f2 = 0;
        end else if (flush) begin
            m_valid = 0;
        end else if (in_valid && rdy) begin
            m_valid = 1; m_op = in_inst[31:26]; m_off = in_inst[15:0]; m_pc = in_pc;
            m_rd = in_inst[25:21]; m_rsn = a1; m_rtn = a2; m_f1 = f1; m_f2 = f2;
            m_rs = fwd(a1, f1, f1 ? rf_flt[a1] : rf_int[a1]);
            m_rt = fwd(a2, f2, f2 ? rf_flt[a2] : rf_int[a2]);
        end else if (adv) begin
            m_valid = 0;
            if (haz && m_bub < MAXB) m_bub++;
        end else begin
            m_rs = fwd(m_rsn, m_f1, m_rs);
            m_rt = fwd(m_rtn, m_f2, m_rt);
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("bubble_cnt", bubble_cnt, m_bub);
        if (m_valid || was_rst) begin
            chk("opecode", opecode, m_op);
            chk("offset", offset, m_off);
            chk("pc_out", pc_out, m_pc);
            chk("rs", rs, m_rs);
            chk("rt", rt, m_rt);
            chk("rd_no", rd_no, m_rd);
            chk("rs_no", rs_no, m_rsn);
            chk("rt_no", rt_no, m_rtn);
            chk("fmode1_reg", fmode1_reg, m_f1);
            chk("fmode2_reg", fmode2_reg, m_f2);
        end
        @(negedge clk);
    endtask

    task automatic clr_byp();
        byp_valid = '0; byp_fmode = '0; byp_rd = '0; byp_data = '0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf_int[i] = $urandom;
            rf_flt[i] = $urandom;
        end
        rf_int[0] = 32'h0;
        rf_int[3] = 32'h11;
        rf_int[4] = 32'h22;
        m_valid = 0; m_bub = 0;
        rstn = 0; in_valid = 0; flush = 0; out_ready = 1; in_pc = 32'h100; in_inst = '0;
        clr_byp();

        // Reset
        cycle();
        cycle();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_bubble_cnt", bubble_cnt, 0);
        rstn = 1;

        // Simple add
        in_valid = 1; in_pc = 32'h200; in_inst = enc(OPC_ADD, 5'd6, 5'd3, 5'd4, 11'h0);
        cycle();
        chk("add_valid", out_valid, 1'b1);
        chk("add_rs", rs, 32'h11);
        chk("add_rt", rt, 32'h22);
        chk("add_rd", rd_no, 5'd6);
        chk("add_op", opecode, OPC_ADD);
        in_valid = 0;
        cycle();
        chk("idle_valid", out_valid, 1'b0);

        // Load-use bubble, then operand arrives via bypass 0
        in_valid = 1; in_inst = enc(OPC_LW, 5'd5, 5'd1, 5'd0, 11'h40);
        cycle();
        in_inst = enc(OPC_ADD, 5'd2, 5'd5, 5'd0, 11'h0);
        #1;
        chk("ldu_ready", in_ready, 1'b0);
        cycle();
        chk("ldu_bubble", bubble_cnt, 1);
        byp_valid = 2'b01; byp_rd = {5'd0, 5'd5}; byp_data = {32'h0, 32'hDEAD};
        cycle();
        chk("ldu_rs", rs, 32'hDEAD);
        chk("ldu_valid", out_valid, 1'b1);

        // Bypass priority, file mismatch and r0
        in_inst = enc(OPC_ADD, 5'd1, 5'd7, 5'd7, 11'h0);
        byp_valid = 2'b11; byp_fmode = 2'b00; byp_rd = {5'd7, 5'd7};
        byp_data = {32'hBBBB, 32'hAAAA};
        cycle();
        chk("byp_prio", rs, 32'hAAAA);
        in_inst = enc(OPC_FADD, 5'd1, 5'd7, 5'd7, 11'h0);
        cycle();
        chk("byp_fmode", rs, rf_flt[7]);
        in_inst = enc(OPC_ADD, 5'd1, 5'd0, 5'd0, 11'h0);
        byp_rd = {5'd0, 5'd0}; byp_data = {32'h2222, 32'h1111};
        cycle();
        chk("byp_r0", rs, rf_int[0]);

        // Hold with refresh from bypass 1
        clr_byp();
        in_inst = enc(OPC_ADD, 5'd3, 5'd2, 5'd9, 11'h0);
        cycle();
        out_ready = 0; in_inst = enc(OPC_SUB, 5'd8, 5'd1, 5'd2, 11'h0);
        byp_valid = 2'b10; byp_rd = {5'd9, 5'd0}; byp_data = {32'h1234, 32'h0};
        for (int k = 0; k < 3; k++) cycle();
        chk("hold_rt", rt, 32'h1234);
        chk("hold_rd", rd_no, 5'd3);
        chk("hold_rs", rs, rf_int[2]);
        out_ready = 1; clr_byp();
        cycle();

        // Flush coinciding with a hazard
        in_inst = enc(OPC_LW, 5'd5, 5'd1, 5'd0, 11'h8);
        cycle();
        in_inst = enc(OPC_ADD, 5'd2, 5'd5, 5'd0, 11'h0);
        flush = 1;
        cycle();
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_bubble", bubble_cnt, 1);
        flush = 0;
        cycle();
        chk("flush_reissue", out_valid, 1'b1);
        chk("flush_rs", rs, rf_int[5]);

        // Register-address selection
        in_valid = 0;
        in_inst = enc(OPC_BEQ, 5'd10, 5'd11, 5'd12, 11'h0);
        #1;
        chk("br_addr2", rf_addr2, 5'd10);
        in_inst = enc(OPC_FMUL, 5'd10, 5'd11, 5'd12, 11'h0);
        #1;
        chk("fmul_fmode1", rf_fmode1, 1'b1);
        chk("fmul_addr2", rf_addr2, 5'd12);
        cycle();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] w;
            rstn      = ($urandom_range(0, 499) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            w = $urandom;
            w[31:26] = ops[$urandom_range(0, 9)];
            w[25:21] = 5'($urandom_range(0, 3));
            w[20:16] = 5'($urandom_range(0, 3));
            w[15:11] = 5'($urandom_range(0, 3));
            in_inst = w;
            in_pc = $urandom;
            byp_valid = 2'($urandom);
            byp_fmode = 2'($urandom);
            byp_rd = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            byp_data = {$urandom, $urandom};
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
